bit_deser8: RTL and testbench



---
 rtl/bit_deser8_pkg.sv | 18 +
 rtl/bit_deser8_if.sv | 42 ++++
 rtl/bit_deser8.sv | 102 ++++++++++
 tb/tb_bit_deser8.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bit_deser8_pkg.sv
// Shared constants and state encoding for the bit_deser8 serial-to-parallel stage.
// Imported by the interface and the deserializer so both agree on WIDTH and bit_cnt sizing.
package bit_deser8_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // bit_cnt must be able to hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_deser8_if.sv
// Serial-in / word-out handshake bundle for bit_deser8.
// slave is the deserializer's view; master is the source/consumer side driving it.
interface bit_deser8_if
    import bit_deser8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) ();

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic             clear;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bits;
    logic [CNT_W-1:0] bit_cnt;

    modport slave (
        input  clear,
        input  in_valid,
        input  in_bit,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_bits,
        output bit_cnt
    );

    modport master (
        output clear,
        output in_valid,
        output in_bit,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_bits,
        input  bit_cnt
    );

endinterface

// File: rtl/bit_deser8.sv
// Serial-to-parallel front stage: assembles WIDTH bits MSB-first and holds the word
// under a valid/ready handshake, backpressuring the serial source while it is held.
module bit_deser8
    import bit_deser8_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    bit_deser8_if.slave    bus
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_ready;
    logic out_valid;
    logic accept;
    logic take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        // out_ready only reaches in_ready while a word is held, so a take and the
        // first bit of the next word can share a cycle.
        case (state_q)
            ST_EMPTY, ST_FILL: in_ready = 1'b1;
            ST_FULL: begin
                out_valid = 1'b1;
                in_ready  = bus.out_ready;
            end
            default: in_ready = 1'b0;
        endcase

        if (bus.clear) begin
            in_ready = 1'b0;
        end

        accept = bus.in_valid & in_ready;
        take   = out_valid & bus.out_ready;

        if (bus.clear) begin
            state_d = ST_EMPTY;
            sreg_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY, ST_FILL: begin
                    if (accept) begin
                        sreg_d  = {sreg_q[WIDTH-2:0], bus.in_bit};
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (cnt_q == LAST_CNT) ? ST_FULL : ST_FILL;
                    end
                end
                ST_FULL: begin
                    if (take) begin
                        if (accept) begin
                            sreg_d  = {{(WIDTH-1){1'b0}}, bus.in_bit};
                            cnt_d   = CNT_W'(1);
                            state_d = ST_FILL;
                        end else begin
                            sreg_d  = '0;
                            cnt_d   = '0;
                            state_d = ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_bits  = sreg_q;
    assign bus.bit_cnt   = cnt_q;

endmodule

// File: tb/tb_bit_deser8.sv
// Self-checking bench for bit_deser8: directed scenarios plus random traffic, each cycle
// compared against a word/count model built from the handshake rules.
module tb_bit_deser8;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    bit_deser8_if #(.WIDTH(W)) bus ();

    bit_deser8 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int take_cycles[$];

    // Model: value of bits gathered so far, how many, and whether a word is held.
    int m_word = 0;
    int m_cnt  = 0;
    bit m_full = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = 0;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    // Entered and left at a falling edge; inputs change here, outputs checked 1ns later.
    task automatic cycle(input logic cl, input logic iv, input logic ib, input logic ordy);
        logic exp_rdy;
        logic acc;
        logic take;
        bus.clear     = cl;
        bus.in_valid  = iv;
        bus.in_bit    = ib;
        bus.out_ready = ordy;
        #1;
        exp_rdy = cl ? 1'b0 : (m_full ? ordy : 1'b1);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_full));
        chk("out_bits", 32'(bus.out_bits), 32'(m_word));
        chk("bit_cnt", 32'(bus.bit_cnt), 32'(m_cnt));
        acc  = iv & exp_rdy;
        take = m_full & ordy & ~cl;
        if (take) take_cycles.push_back(cyc);
        @(posedge clk);
        if (cl) begin
            model_reset();
        end else if (m_full) begin
            if (take) begin
                m_full = 1'b0;
                m_word = acc ? int'(ib) : 0;
                m_cnt  = acc ? 1 : 0;
            end
        end else if (acc) begin
            m_word = (m_word * 2 + int'(ib)) % 256;
            m_cnt  = m_cnt + 1;
            if (m_cnt == W) m_full = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic ordy, input bit gappy);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(1'b0, 1'b1, w[i], ordy);
            if (gappy) cycle(1'b0, 1'b0, 1'($urandom), ordy);
        end
    endtask

    // The word just completed must be presented as-is, and the reducer sees its OR.
    task automatic check_word(input string tag, input logic [7:0] w);
        #1;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_bits"}, 32'(bus.out_bits), 32'(w));
        chk({tag, "_or"}, 32'(bus.out_valid & (|bus.out_bits)), 32'(|w));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bits", 32'(bus.out_bits), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n_takes;
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Reset mid-word after five accepted bits.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'($urandom), 1'b0);
        chk("mid_cnt5", 32'(bus.bit_cnt), 32'd5);
        do_reset();

        // Single set bit, then an all-zero word; out_ready held high throughout.
        take_cycles.delete();
        send_word(8'b0001_0000, 1'b1, 1'b0);
        check_word("w10", 8'b0001_0000);
        send_word(8'h00, 1'b1, 1'b0);
        check_word("w00", 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("takes_two", 32'(take_cycles.size()), 32'd2);

        // Backpressure: hold for four cycles, then take plus first bit together.
        send_word(8'b0010_0110, 1'b0, 1'b0);
        check_word("bp_word", 8'b0010_0110);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom), 1'b0);
            chk("bp_hold", 32'(bus.out_bits), 32'h26);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("bp_cnt1", 32'(bus.bit_cnt), 32'd1);
        for (int i = 0; i < W - 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check_word("bp_next", 8'h80);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back words, takes exactly eight cycles apart.
        take_cycles.delete();
        send_word(8'hFF, 1'b1, 1'b0);
        check_word("ff", 8'hFF);
        send_word(8'h01, 1'b1, 1'b0);
        check_word("01", 8'h01);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_takes", 32'(take_cycles.size()), 32'd2);
        if (take_cycles.size() == 2)
            chk("b2b_gap", 32'(take_cycles[1] - take_cycles[0]), 32'd8);

        // Gappy source: in_valid alternates.
        send_word(8'b1000_0000, 1'b0, 1'b1);
        check_word("gappy", 8'b1000_0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // clear at bit_cnt=6.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_clear_cnt", 32'(bus.bit_cnt), 32'd6);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        send_word(8'h5A, 1'b0, 1'b0);
        check_word("after_clr", 8'h5A);

        // clear while FULL with out_ready=1: the word is dropped.
        n_takes = take_cycles.size();
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_full_cnt", 32'(bus.bit_cnt), 32'd0);
        chk("clr_full_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_full_notake", 32'(take_cycles.size()), 32'(n_takes));
        send_word(8'hC3, 1'b1, 1'b0);
        check_word("after_clr_full", 8'hC3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional clear and one reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            cycle(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
